// File: rtl/ptw_gen2.sv
// ptw_gen2 -- multi-level page-table walker.
//
// Accepts one virtual address at a time and walks LEVELS page-table levels
// starting at ROOT_BASE. It issues exactly one 32-bit memory read per level
// and returns either the leaf PTE or a fault, together with the level where
// the walk ended.
//
// Optional feature: `define PTW_WALK_CACHE_EN enables a one-entry cache.
// The cache holds the base of the last-level table keyed by the upper VPNs,
// so a matching walk needs only one read.
//
// Ports:
//   clk, rst                          clock (rising edge), async active-low reset
//   ptw_req_valid_i/ready_o, vaddr_i  translation request
//   ptw_resp_valid_o/ready_i          result handshake
//   ptw_pte_o, ptw_level_o, ptw_fault_o  result payload
//   ptw_flush_i                       invalidate the walk cache
//   mem_req_valid_o/ready_i, addr_o   memory read request
//   mem_resp_valid_i/ready_o, data_i  memory read response
module ptw_gen2 #(
  parameter int          LEVELS    = 2,
  parameter int          VPN_W     = 10,
  parameter logic [31:0] ROOT_BASE = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ptw_req_valid_i,
  output logic        ptw_req_ready_o,
  input  logic [31:0] ptw_vaddr_i,
  output logic        ptw_resp_valid_o,
  input  logic        ptw_resp_ready_i,
  output logic [31:0] ptw_pte_o,
  output logic [1:0]  ptw_level_o,
  output logic        ptw_fault_o,
  input  logic        ptw_flush_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;

  localparam logic [31:0] VPN_MASK = (32'd1 << VPN_W) - 32'd1;

  state_t      state;
  logic [31:0] va;
  logic [31:0] base;
  logic [1:0]  lvl;
  logic [31:0] res_pte;
  logic [1:0]  res_lvl;
  logic        res_fault;

  // VPN field k of an address, already right-aligned.
  function automatic logic [31:0] vpn_of(input logic [31:0] a, input logic [1:0] k);
    return (a >> (12 + VPN_W * int'(k))) & VPN_MASK;
  endfunction

  // PTE decode of the incoming memory word.
  logic pv, pr, pw, px, prwx, bad;
  always_comb begin
    pv   = mem_data_i[0];
    pr   = mem_data_i[1];
    pw   = mem_data_i[2];
    px   = mem_data_i[3];
    prwx = pr | pw | px;
    // Invalid, reserved W-without-R, or a pointer out of the last level.
    bad  = !pv || (pw && !pr) || (!prwx && lvl == 2'd0);
  end

  assign ptw_req_ready_o  = (state == IDLE);
  assign ptw_resp_valid_o = (state == RESP);
  assign mem_req_valid_o  = (state == MREQ);
  assign mem_resp_ready_o = (state == MWAIT);
  // Address arithmetic wraps modulo 2^32.
  assign mem_addr_o       = (state == MREQ) ? base + (vpn_of(va, lvl) << 2) : 32'd0;
  assign ptw_pte_o        = res_pte;
  assign ptw_level_o      = res_lvl;
  assign ptw_fault_o      = res_fault;

`ifdef PTW_WALK_CACHE_EN
  localparam int          TAG_SH   = 12 + VPN_W;
  localparam logic [31:0] TAG_MASK = (LEVELS > 1) ?
                                     (32'd1 << (VPN_W * (LEVELS - 1))) - 32'd1 : 32'd0;

  logic        c_vld;
  logic [31:0] c_tag;
  logic [31:0] c_base;
  logic        hit;

  // With one level there is no upper VPN to key on, so never hit.
  assign hit = (LEVELS > 1) && c_vld && (((ptw_vaddr_i >> TAG_SH) & TAG_MASK) == c_tag);
`else
  logic unused_flush;
  assign unused_flush = ptw_flush_i;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      va        <= '0;
      base      <= '0;
      lvl       <= '0;
      res_pte   <= '0;
      res_lvl   <= '0;
      res_fault <= 1'b0;
`ifdef PTW_WALK_CACHE_EN
      c_vld     <= 1'b0;
      c_tag     <= '0;
      c_base    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (ptw_req_valid_i) begin
          va    <= ptw_vaddr_i;
          lvl   <= 2'(LEVELS - 1);
          base  <= ROOT_BASE;
`ifdef PTW_WALK_CACHE_EN
          if (hit) begin
            lvl  <= 2'd0;
            base <= c_base;
          end
`endif
          state <= MREQ;
        end
        MREQ: if (mem_req_ready_i) state <= MWAIT;
        MWAIT: if (mem_resp_valid_i) begin
          if (bad) begin
            res_pte   <= '0;
            res_lvl   <= lvl;
            res_fault <= 1'b1;
            state     <= RESP;
          end else if (!prwx) begin
            base  <= {mem_data_i[31:10], 10'b0};
            lvl   <= lvl - 2'd1;
            state <= MREQ;
`ifdef PTW_WALK_CACHE_EN
            if (lvl == 2'd1) begin
              c_vld  <= 1'b1;
              c_tag  <= (va >> TAG_SH) & TAG_MASK;
              c_base <= {mem_data_i[31:10], 10'b0};
            end
`endif
          end else begin
            res_pte   <= mem_data_i;
            res_lvl   <= lvl;
            res_fault <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: if (ptw_resp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef PTW_WALK_CACHE_EN
      // Placed after the fill so a same-edge flush overrides it.
      if (ptw_flush_i) c_vld <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/ptw_gen2.md
PTW_GEN2 -- requirements
Module: ptw_gen2

Interface
REQ-001 Parameter LEVELS, 2, number of page-table levels walked; legal range 1..3.
REQ-002 Parameter VPN_W, 10, bits per VPN field; VPN[k] = vaddr[12+VPN_W*(k+1)-1 : 12+VPN_W*k].
REQ-003 Parameter ROOT_BASE, 32'h0000_0400, byte address of the root page table.
REQ-004 clk  input  1  clock, rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 ptw_req_valid_i  input  1  translation request valid.
REQ-007 ptw_req_ready_o  output  1  walker idle, can accept a request.
REQ-008 ptw_vaddr_i  input  32  virtual address to translate.
REQ-009 ptw_resp_valid_o  output  1  walk result valid.
REQ-010 ptw_resp_ready_i  input  1  requester accepts result.
REQ-011 ptw_pte_o  output  32  leaf PTE, or 0 on fault.
REQ-012 ptw_level_o  output  2  level of leaf or fault (0 = last level; >0 = superpage).
REQ-013 ptw_fault_o  output  1  walk ended in a page fault.
REQ-014 ptw_flush_i  input  1  invalidate walk cache.
REQ-015 mem_req_valid_o / mem_req_ready_i / mem_addr_o (32): memory read request channel.
REQ-016 mem_resp_valid_i / mem_resp_ready_o / mem_data_i (32): memory read response channel.

Function
REQ-017 FSM states IDLE, MREQ, MWAIT, RESP; ptw_req_ready_o = (state==IDLE).
REQ-018 IDLE: on valid&&ready, register vaddr, set lvl=LEVELS-1, base=ROOT_BASE, go MREQ.
REQ-019 MREQ: mem_req_valid_o=1, mem_addr_o = base + {VPN[lvl],2'b00}, both stable until mem_req_ready_i; on handshake go MWAIT.
REQ-020 MWAIT: mem_resp_ready_o=1, others 0; on mem_resp_valid_i capture mem_data_i and decode in the same edge.
REQ-021 Decode: V=pte[0], R=pte[1], W=pte[2], X=pte[3]; V=0 or (W=1 && R=0) -> fault.
REQ-022 R|W|X=0 with V=1 is a pointer: lvl==0 -> fault; else base={pte[31:10],10'b0}, lvl=lvl-1, go MREQ.
REQ-023 R|W|X!=0 with V=1 is a leaf: pte_o=pte, level_o=lvl, fault_o=0, go RESP.
REQ-024 Fault: pte_o=0, fault_o=1, level_o=lvl, go RESP.
REQ-025 RESP: resp_valid_o=1, pte/level/fault stable until ptw_resp_ready_i; on handshake go IDLE; no new request accepted before.
REQ-026 Latency with zero-wait memory: resp_valid_o rises after the 2N-th edge following acceptance, N = memory reads performed.
REQ-027 Address arithmetic 32-bit, wraps modulo 2^32; vaddr bits above the top VPN are ignored.
REQ-028 Exactly one memory read per level visited; no read is reissued or speculated.

Reset
REQ-029 rst low: state IDLE, ptw_req_ready_o=1, all other outputs 0, internal registers and cache valid cleared.
REQ-030 Reset mid-walk abandons the in-flight transaction; no response issued; memory is reset concurrently.

Configuration
REQ-031 Macro PTW_WALK_CACHE_EN defined: one-entry cache {valid, tag=VPN[LEVELS-1:1], base of level-0 table}, filled when a pointer PTE at lvl==1 is followed.
REQ-032 With cache, a request whose tag matches a valid entry starts at lvl=0 with the cached base (single read); faults never fill.
REQ-033 ptw_flush_i clears valid at the next edge; flush and fill on the same edge -> flush wins; LEVELS==1 -> cache never hits.
REQ-034 Macro undefined: no cache storage, ptw_flush_i ignored, every walk starts at ROOT_BASE.

Verification
(LEVELS=2; memory: 0x400=0x00000801, 0x404=0x12340000, 0x408=0, 0x40C=0x2000000F; 0x800=0x1000000F, 0x804=0x1100000F, 0x808=0x12000007, 0x80C=0.)
REQ-035 vaddr 0x00001000 -> reads 0x400 then 0x804; pte 0x1100000F, level 0, fault 0.
REQ-036 vaddr 0x00400000 -> single read 0x404; pte 0, fault 1, level 1; vaddr 0x00003000 -> pte 0, fault 1, level 0.
REQ-037 vaddr 0x00C00000 -> single read 0x40C; pte 0x2000000F, level 1, fault 0.
REQ-038 mem_req_ready_i low 3 cycles, ptw_resp_ready_i low 5 cycles -> mem_addr_o and pte_o held stable; exactly two reads; result 0x1000000F.
REQ-039 Macro on: 0x00000000 then 0x00002000 -> second walk single read 0x808, pte 0x12000007; pulse ptw_flush_i, repeat -> reads 0x400, 0x808.
REQ-040 rst low during MWAIT -> ready_o=1, resp_valid_o=0 at once; next request 0x00000000 returns 0x1000000F.
